// File: rtl/router_pkg.sv
// router_pkg: shared definitions for the router output arbiter.
//   NPORT       - number of FIFO ports merged onto the egress link
//   LEN_HI/LO   - header bit slice holding the payload length
//   GRANT_NONE  - grant encoding when no port owns the link
//   arb_state_e - arbiter FSM states
//   beat_t      - one buffered egress beat {data, sop, eop}
//   rr_pick     - round-robin search starting after the last served port
package router_pkg;

    localparam int         NPORT      = 3;
    localparam int         DW         = 8;
    localparam int         LEN_HI     = 7;
    localparam int         LEN_LO     = 2;
    localparam logic [1:0] GRANT_NONE = 2'd3;

    typedef enum logic [1:0] {IDLE, HDR, LEN, BODY} arb_state_e;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          sop;
        logic          eop;
    } beat_t;

    // First requesting port searching ptr+1, ptr+2, ptr (mod NPORT).
    // The loop runs from the farthest offset down so the nearest one wins.
    function automatic logic [1:0] rr_pick(input logic [1:0] ptr, input logic [NPORT-1:0] req);
        logic [1:0] idx;
        rr_pick = GRANT_NONE;
        for (int i = NPORT; i >= 1; i--) begin
            idx = 2'((int'(ptr) + i) % NPORT);
            if (req[idx]) rr_pick = idx;
        end
    endfunction

endpackage

// File: rtl/router_out_buf.sv
// router_out_buf: 2-entry FIFO of egress beats {data, sop, eop}.
//   clk, rst           - clock, asynchronous active-high reset
//   push_i, push_*_i   - write one beat
//   pop_i              - remove head (only asserted while valid_o)
//   head_*_o, valid_o  - head beat; fields read as zero when empty
//   occ_o              - current occupancy 0..2
module router_out_buf
    import router_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  logic [DW-1:0] push_data_i,
    input  logic          push_sop_i,
    input  logic          push_eop_i,
    input  logic          pop_i,
    output logic [DW-1:0] head_data_o,
    output logic          head_sop_o,
    output logic          head_eop_o,
    output logic          valid_o,
    output logic [1:0]    occ_o
);

    beat_t      mem_q [2];
    logic       wr_q, rd_q;
    logic [1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) mem_q[i] <= '0;
            wr_q  <= 1'b0;
            rd_q  <= 1'b0;
            cnt_q <= 2'd0;
        end else begin
            if (push_i) begin
                mem_q[wr_q] <= '{data: push_data_i, sop: push_sop_i, eop: push_eop_i};
                wr_q        <= ~wr_q;
            end
            if (pop_i) rd_q <= ~rd_q;
            cnt_q <= cnt_q + 2'(push_i) - 2'(pop_i);
        end
    end

    assign valid_o     = (cnt_q != 2'd0);
    assign occ_o       = cnt_q;
    // Gate the head so the egress pins read as zero whenever nothing is queued.
    assign head_data_o = valid_o ? mem_q[rd_q].data : '0;
    assign head_sop_o  = valid_o & mem_q[rd_q].sop;
    assign head_eop_o  = valid_o & mem_q[rd_q].eop;

endmodule

// File: rtl/router_out_arbiter.sv
// router_out_arbiter: packet-atomic round-robin read scheduler merging the
// router's three output FIFOs onto one valid/ready byte channel.
//   clk, rst             - clock, asynchronous active-high reset
//   vald_out[2:0]        - per-port FIFO non-empty
//   data_out_0/1/2       - FIFO read data, valid one cycle after read_enb
//   read_enb[2:0]        - one-hot FIFO read strobes
//   m_data/m_valid/m_sop/m_eop, m_ready - egress beat and handshake
//   grant                - port owning the link, 3 when none
//   abort                - one-cycle pulse when a stalled packet is dropped
module router_out_arbiter
    import router_pkg::*;
#(
    parameter int TIMEOUT = 30
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [2:0]    vald_out,
    input  logic [DW-1:0] data_out_0,
    input  logic [DW-1:0] data_out_1,
    input  logic [DW-1:0] data_out_2,
    output logic [2:0]    read_enb,
    output logic [DW-1:0] m_data,
    output logic          m_valid,
    output logic          m_sop,
    output logic          m_eop,
    input  logic          m_ready,
    output logic [1:0]    grant,
    output logic          abort
);

    localparam int TW = $clog2(TIMEOUT + 1);

    arb_state_e    state_q, state_d;
    logic [1:0]    grant_q, grant_d, ptr_q, ptr_d;
    logic [6:0]    rem_q, rem_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          abort_q, abort_d;
    logic          infl_q, infl_sop_q, infl_eop_q;

    logic          want, rd, rd_sop, rd_eop;
    logic          vald_g, pop, credit_ok;
    logic [DW-1:0] data_g;
    logic [1:0]    occ;

    always_comb begin
        data_g = '0;
        vald_g = 1'b0;
        case (grant_q)
            2'd0:    begin data_g = data_out_0; vald_g = vald_out[0]; end
            2'd1:    begin data_g = data_out_1; vald_g = vald_out[1]; end
            2'd2:    begin data_g = data_out_2; vald_g = vald_out[2]; end
            default: ;
        endcase
    end

    assign pop = m_valid & m_ready;
    // Occupancy is taken after this cycle's departure: a read issued now lands
    // next cycle together with the byte already in flight, so it must still fit.
    // Counting the departing beat lets a drained head keep 1 byte/cycle flowing.
    assign credit_ok = (3'(occ) + 3'(infl_q) - 3'(pop)) < 3'd2;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        rem_d   = rem_q;
        tmo_d   = tmo_q;
        abort_d = 1'b0;
        want    = 1'b0;
        rd_sop  = 1'b0;
        rd_eop  = 1'b0;

        case (state_q)
            IDLE: begin
                tmo_d = '0;
                if (|vald_out) begin
                    grant_d = rr_pick(ptr_q, vald_out);
                    state_d = HDR;
                end
            end
            HDR:  want = 1'b1;
            LEN: begin
                // Header byte is on data_g now; remaining covers payload + parity.
                if (infl_q) begin
                    rem_d   = 7'(data_g[LEN_HI:LEN_LO]) + 7'd1;
                    state_d = BODY;
                end
            end
            BODY: begin
                want = (rem_q != 7'd0);
                if (!want && !infl_q) begin
                    ptr_d   = grant_q;
                    grant_d = GRANT_NONE;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        rd = want & vald_g & credit_ok;

        if (want) begin
            if (rd) begin
                tmo_d = '0;
                if (state_q == HDR) begin
                    rd_sop  = 1'b1;
                    state_d = LEN;
                end else begin
                    rem_d  = rem_q - 7'd1;
                    rd_eop = (rem_q == 7'd1);
                end
            end else if (credit_ok) begin
                // Starved by an empty FIFO, not by back-pressure.
                if (tmo_q == TW'(TIMEOUT - 1)) begin
                    abort_d = 1'b1;
                    ptr_d   = grant_q;
                    grant_d = GRANT_NONE;
                    rem_d   = 7'd0;
                    tmo_d   = '0;
                    state_d = IDLE;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            grant_q    <= GRANT_NONE;
            ptr_q      <= 2'd2;
            rem_q      <= 7'd0;
            tmo_q      <= '0;
            abort_q    <= 1'b0;
            infl_q     <= 1'b0;
            infl_sop_q <= 1'b0;
            infl_eop_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            ptr_q      <= ptr_d;
            rem_q      <= rem_d;
            tmo_q      <= tmo_d;
            abort_q    <= abort_d;
            infl_q     <= rd;
            infl_sop_q <= rd_sop;
            infl_eop_q <= rd_eop;
        end
    end

    // The in-flight byte belongs to grant_q: grant only changes on a cycle
    // with no read, so the port that was strobed is still selected here.
    router_out_buf u_buf (
        .clk         (clk),
        .rst         (rst),
        .push_i      (infl_q),
        .push_data_i (data_g),
        .push_sop_i  (infl_sop_q),
        .push_eop_i  (infl_eop_q),
        .pop_i       (pop),
        .head_data_o (m_data),
        .head_sop_o  (m_sop),
        .head_eop_o  (m_eop),
        .valid_o     (m_valid),
        .occ_o       (occ)
    );

    assign read_enb = rd ? (3'b001 << grant_q) : 3'b000;
    assign grant    = grant_q;
    assign abort    = abort_q;

endmodule
